// File: rtl/fib_pkg.sv
// Shared definitions for the Zeckendorf encoder: FSM encoding, code-width helper
// and the Fibonacci weight table F(2)..F(25).
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2,
    FINISH  = 2'd3
  } zeck_state_e;

  // Smallest CODE_W with F(CODE_W+2) > 2^data_w - 1.
  function automatic int fib_code_w(input int data_w);
    longint fa, fb, t, max_v;
    int     cw;
    fa    = 1;
    fb    = 2;
    cw    = 1;
    max_v = (longint'(1) << data_w) - 1;
    while (fb <= max_v) begin
      t  = fa + fb;
      fa = fb;
      fb = t;
      cw++;
    end
    return cw;
  endfunction

  localparam int FIB_N = 24;
  localparam logic [31:0] FIB_TABLE [0:FIB_N-1] = '{
    32'd1,     32'd2,     32'd3,     32'd5,     32'd8,     32'd13,
    32'd21,    32'd34,    32'd55,    32'd89,    32'd144,   32'd233,
    32'd377,   32'd610,   32'd987,   32'd1597,  32'd2584,  32'd4181,
    32'd6765,  32'd10946, 32'd17711, 32'd28657, 32'd46368, 32'd75025
  };

endpackage

// File: rtl/zeckendorf_encoder.sv
// Iterative greedy Zeckendorf encoder: climbs the Fibonacci ladder, then walks
// back down taking every term that fits. Optional code_len output via ZECK_LEN_EN.
module zeckendorf_encoder
  import fib_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CODE_W = fib_code_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value_in,
  output logic              busy,
  output logic              done,
`ifdef ZECK_LEN_EN
  output logic [4:0]        code_len,
`endif
  output logic [CODE_W-1:0] code_out
);

  zeck_state_e       state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W:0]   a_q, a_d, b_q, b_d;
  logic [4:0]        k_q, k_d;
  logic [CODE_W-1:0] acc_q, acc_d, code_q, code_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DATA_W:0]   rem_ext, sum;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    acc_d   = acc_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_ext = {1'b0, rem_q};
    sum     = a_q + b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = value_in;
          a_d     = (DATA_W+1)'(1);
          b_d     = (DATA_W+1)'(2);
          k_d     = 5'd0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = (value_in == '0) ? FINISH : ASCEND;
        end
      end
      ASCEND: begin
        // Exit is decided in the same cycle as the last step, so each ascend
        // cycle is exactly one ladder step.
        if (b_q <= rem_ext) begin
          a_d = b_q;
          b_d = sum;
          k_d = k_q + 5'd1;
          if (sum > rem_ext) state_d = DESCEND;
        end else begin
          state_d = DESCEND;
        end
      end
      DESCEND: begin
        if (a_q <= rem_ext) begin
          acc_d[k_q] = 1'b1;
          rem_d      = rem_q - a_q[DATA_W-1:0];
        end
        a_d = b_q - a_q;
        b_d = a_q;
        k_d = k_q - 5'd1;
        if (k_q == 5'd0) state_d = FINISH;
      end
      FINISH: begin
        code_d  = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign code_out = code_q;

`ifdef ZECK_LEN_EN
  logic [4:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (state_q == FINISH) begin
      len_d = 5'd0;
      for (int i = 0; i < CODE_W; i++)
        if (acc_q[i]) len_d = 5'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) len_q <= '0;
    else      len_q <= len_d;
  end

  assign code_len = len_q;
`endif

endmodule

// File: tb/tb_zeckendorf_encoder.sv
// Directed + randomized bench for zeckendorf_encoder against a greedy FIB_TABLE model.
module tb_zeckendorf_encoder;
  import fib_pkg::*;

  localparam int DATA_W = 16;
  localparam int CODE_W = 23;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] value_in = '0;
  logic              busy, done;
  logic [CODE_W-1:0] code_out;
`ifdef ZECK_LEN_EN
  logic [4:0]        code_len;
`endif

  int checks = 0;
  int errors = 0;

  zeckendorf_encoder #(.DATA_W(DATA_W), .CODE_W(CODE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
`ifdef ZECK_LEN_EN
    .code_len (code_len),
`endif
    .code_out (code_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Greedy decomposition straight from the Fibonacci table.
  function automatic logic [CODE_W-1:0] model_code(input int v);
    logic [CODE_W-1:0] c;
    int r;
    c = '0;
    r = v;
    for (int i = CODE_W - 1; i >= 0; i--)
      if (int'(FIB_TABLE[i]) <= r) begin
        c[i] = 1'b1;
        r -= int'(FIB_TABLE[i]);
      end
    return c;
  endfunction

  function automatic int weight(input logic [CODE_W-1:0] c);
    int s;
    s = 0;
    for (int i = 0; i < CODE_W; i++)
      if (c[i]) s += int'(FIB_TABLE[i]);
    return s;
  endfunction

  function automatic int top_len(input logic [CODE_W-1:0] c);
    int l;
    l = 0;
    for (int i = 0; i < CODE_W; i++)
      if (c[i]) l = i + 1;
    return l;
  endfunction

  // Start one encode; returns the code, cycles from start edge to done, and
  // whether busy behaved. Optionally re-pulses start (value 5) mid-operation.
  task automatic encode(input logic [DATA_W-1:0] v, input bit repulse,
                        output logic [CODE_W-1:0] code, output int lat, output bit busy_ok);
    @(negedge clk);
    value_in = v;
    start    = 1'b1;
    busy_ok  = 1'b1;
    @(posedge clk); #1;
    lat   = 1;
    start = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (repulse && lat == 3) begin start = 1'b1; value_in = 16'd5; end
      if (repulse && lat == 4) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (busy) busy_ok = 1'b0;
    code = code_out;
  endtask

  initial begin
    logic [CODE_W-1:0] code, exp_code;
    int lat, kmax;
    bit bok;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] seq_v [3];
    logic [CODE_W-1:0] seq_c [3];
    seq_v = '{16'd1, 16'd4, 16'd7};
    seq_c = '{23'h1, 23'h5, 23'hA};

    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_code", 64'(code_out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    encode(16'd0, 1'b0, code, lat, bok);
    chk("zero_code", 64'(code), 64'h0);
    chk("zero_lat", 64'(lat), 64'd2);
    chk("zero_busy", 64'(bok), 64'd1);
    @(posedge clk); #1;
    chk("zero_busy_low", 64'(busy), 64'd0);

    encode(16'd100, 1'b0, code, lat, bok);
    chk("v100_code", 64'(code), 64'h000214);
    chk("v100_lat", 64'(lat), 64'd21);
    chk("v100_busy", 64'(bok), 64'd1);
    @(posedge clk); #1;
    chk("v100_done_pulse", 64'(done), 64'd0);

    for (int i = 0; i < 3; i++) begin
      encode(seq_v[i], 1'b0, code, lat, bok);
      chk("b2b_code", 64'(code), 64'(seq_c[i]));
    end

    encode(16'd65535, 1'b0, code, lat, bok);
    chk("max_code", 64'(code), 64'h505204);
    chk("max_lat", 64'(lat), 64'd47);
`ifdef ZECK_LEN_EN
    chk("max_len", 64'(code_len), 64'd23);
`endif

    encode(16'd100, 1'b1, code, lat, bok);
    chk("repulse_code", 64'(code), 64'h000214);
    chk("repulse_lat", 64'(lat), 64'd21);

    // Abort mid-ascent.
    @(negedge clk);
    value_in = 16'd65535;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_code", 64'(code_out), 64'd0);
`ifdef ZECK_LEN_EN
    chk("abort_len", 64'(code_len), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done), 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      v = 16'($urandom_range(0, 65535));
      exp_code = model_code(int'(v));
      encode(v, 1'b0, code, lat, bok);
      chk("rnd_code", 64'(code), 64'(exp_code));
      chk("rnd_adjacent", 64'(code & (code >> 1)), 64'd0);
      chk("rnd_weight", 64'(weight(code)), 64'(v));
      chk("rnd_busy", 64'(bok), 64'd1);
      kmax = top_len(exp_code) - 1;
      if (v >= 16'd2) chk("rnd_lat", 64'(lat), 64'(2 * kmax + 3));
`ifdef ZECK_LEN_EN
      chk("rnd_len", 64'(code_len), 64'(top_len(exp_code)));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeckendorf_encoder.md
Name: zeckendorf_encoder

Overview:
Iterative encoder that converts an unsigned binary integer into its Zeckendorf (Fibonacci-base) code word. Works in the opposite direction from the block that computes F(n) from n: it takes a value, decomposes it greedily into non-consecutive Fibonacci numbers and emits a one-hot-per-term bit vector. It sits between the integer datapath and the Fibonacci-binary obfuscation logic. Sequential, one add/subtract per cycle, with a start/busy/done handshake.

Parameters:
DATA_W, 16, width of the input value.
CODE_W, 23, output code width; bit j has weight F(j+2), so F(2)..F(24) covers all values below 2^16. Must satisfy F(CODE_W+2) > 2^DATA_W - 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
value_in  input  DATA_W  integer to encode; latched on an accepted start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when code_out is valid.
code_out  output  CODE_W  Zeckendorf code; held until the next done.

Behaviour:
- Reset (rst=0, asynchronous): busy=0, done=0, code_out=0, state=IDLE, internal registers cleared. A reset asserted mid-operation aborts the operation with no done pulse.
- Internal registers: rem (DATA_W), a and b (DATA_W+1 bits each, so b never overflows), k (5 bits), acc (CODE_W).
- IDLE: if start=1, then rem<=value_in, a<=1 (F2), b<=2 (F3), k<=0 (bit index of a), acc<=0, busy<=1.
  - If value_in=0, go to FINISH.
  - Otherwise go to ASCEND.
  - A start asserted while busy=1 is ignored.
- ASCEND: while b <= rem: a<=b, b<=a+b, k<=k+1. When b > rem, go to DESCEND without changing a, b or k.
- DESCEND, one cycle per term:
  - If a <= rem: acc[k]<=1 and rem<=rem-a.
  - Then a<=b-a, b<=a, k<=k-1.
  - When k=0 is processed, go to FINISH.
  - Greedy selection guarantees that no two adjacent bits are set and that rem=0 on exit.
- FINISH: code_out<=acc, done<=1 for exactly this cycle, busy<=0, return to IDLE. A start may be accepted on the cycle after done.
- Latency from start to done: 1 + (ascend steps) + (k_max + 1) + 1 cycles. For value 65535 this is 1+22+23+1 = 47 cycles maximum. For value 0 it is 2 cycles.
- All arithmetic is unsigned. Subtraction occurs only when a <= rem, so it never underflows.

Optional Feature:
ZECK_LEN_EN: adds an output port code_len (5 bits) that equals the index of the highest set bit of code_out plus 1, or 0 for value 0. It is registered together with code_out at done, and its reset value is 0. Without the macro, the port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package fib_pkg holds:
  - the state encoding (IDLE, ASCEND, DESCEND, FINISH);
  - the constant function fib_code_w(data_w), which returns the minimal CODE_W;
  - the localparam table FIB_TABLE of F(2)..F(25), used by the bench as a reference model.
- No sub-module: the datapath is a single adder/subtractor plus a comparator, so it stays inline.

Test Plan:
- Reset then value_in=0, start pulse → done two cycles later, code_out=0x000000, busy returns low.
- value_in=100 → code_out=0x000214 (89+8+3, bits 9, 4, 2). Check that busy is high throughout and done lasts exactly 1 cycle.
- value_in=1, 4, 7 back-to-back, each start issued the cycle after the previous done → code_out=0x1, 0x5, 0xA respectively.
- value_in=65535 → code_out=0x505204 (bits 22, 20, 14, 12, 9, 2), latency exactly 47 cycles. With ZECK_LEN_EN, code_len=23.
- start re-pulsed with value_in=5 while busy during the encoding of 100 → ignored, result stays 0x000214. Then rst low mid-ASCEND → busy=0, no done, code_out=0.
- Random sweep of 0..65535 against a FIB_TABLE model → code_out matches the model, no two adjacent ones, and the weighted sum equals value_in.
